// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: phase encoding and
// small helpers used by the phase sequencer, the datapath and the bench.
package datapath_pkg;

  localparam int PHASE_W    = 3;
  localparam int NUM_PHASES = 7;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_FETCH     = 3'd1,
    PH_DECODE    = 3'd2,
    PH_EXECUTE   = 3'd3,
    PH_MEMORY    = 3'd4,
    PH_WRITEBACK = 3'd5,
    PH_HALTED    = 3'd6
  } phase_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control bundle between the phase sequencer and the datapath it times.
// The datapath side supplies decoded controls and the memory handshake;
// the sequencer returns phase strobes and status.
interface phase_sequencer_if;
  import datapath_pkg::*;

  logic        run;
  logic        halt_req;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_ready;

  logic        imem_en;
  logic        rf_read_en;
  logic        ex_en;
  logic        mem_en;
  logic        rf_write_en;
  logic        pc_we;
  phase_t      phase;
  logic        busy;
  logic        halted;
  logic        mem_error;
  logic [31:0] instr_count;

  modport master (
    output run, halt_req, mem_read, mem_write, reg_write, mem_ready,
    input  imem_en, rf_read_en, ex_en, mem_en, rf_write_en, pc_we,
    input  phase, busy, halted, mem_error, instr_count
  );

  modport slave (
    input  run, halt_req, mem_read, mem_write, reg_write, mem_ready,
    output imem_en, rf_read_en, ex_en, mem_en, rf_write_en, pc_we,
    output phase, busy, halted, mem_error, instr_count
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting in the MEMORY phase. expired is high in the
// LIMIT-th enabled cycle since the last clear, so the caller can give up
// on that same cycle if the access still has not completed.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wait counter: cleared outside the wait, stops at the last value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and emits one enable per phase.
// The datapath runs entirely on clk qualified by these enables.
module phase_sequencer
  import datapath_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [31:0] MAX_INSTR   = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  phase_sequencer_if.slave  bus
);

  phase_t      state;
  logic [31:0] instr_count;
  logic        mem_error;
  logic        mem_access;
  logic        timer_expired;
  logic [31:0] count_inc;
  logic        limit_hit;

  assign mem_access = bus.mem_read | bus.mem_write;
  assign count_inc  = sat_inc32(instr_count);
  assign limit_hit  = (MAX_INSTR != 32'd0) && (count_inc == MAX_INSTR);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != PH_MEMORY),
    .enable  ((state == PH_MEMORY) && mem_access),
    .expired (timer_expired)
  );

  // Phase FSM plus the retired-instruction counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PH_IDLE;
      instr_count <= 32'd0;
      mem_error   <= 1'b0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (bus.run) state <= PH_FETCH;
        end
        PH_FETCH:   state <= PH_DECODE;
        PH_DECODE:  state <= PH_EXECUTE;
        PH_EXECUTE: state <= PH_MEMORY;
        PH_MEMORY: begin
          // A completing access wins over a timeout in the same cycle.
          if (!mem_access || bus.mem_ready) begin
            state <= PH_WRITEBACK;
          end else if (timer_expired) begin
            mem_error <= 1'b1;
            state     <= PH_HALTED;
          end
        end
        PH_WRITEBACK: begin
          instr_count <= count_inc;
          if (bus.halt_req || limit_hit) state <= PH_HALTED;
          else                           state <= PH_FETCH;
        end
        PH_HALTED: state <= PH_HALTED;
        default:   state <= PH_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the phase register.
  assign bus.imem_en     = (state == PH_FETCH);
  assign bus.rf_read_en  = (state == PH_DECODE);
  assign bus.ex_en       = (state == PH_EXECUTE);
  assign bus.mem_en      = (state == PH_MEMORY) && mem_access;
  assign bus.rf_write_en = (state == PH_WRITEBACK) && bus.reg_write;
  assign bus.pc_we       = (state == PH_WRITEBACK);
  assign bus.phase       = state;
  assign bus.busy        = (state != PH_IDLE) && (state != PH_HALTED);
  assign bus.halted      = (state == PH_HALTED);
  assign bus.mem_error   = mem_error;
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Stimulus pushes cycle-tagged
// expectations into a scoreboard; a monitor compares them at the falling
// edge of the cycle they belong to.
module tb_phase_sequencer;
  import datapath_pkg::*;

  localparam int SIG_PHASE  = 0;
  localparam int SIG_STROBE = 1;
  localparam int SIG_BUSY   = 2;
  localparam int SIG_HALTED = 3;
  localparam int SIG_MERR   = 4;
  localparam int SIG_COUNT  = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  phase_sequencer_if bus ();

  phase_sequencer #(
    .MEM_TIMEOUT (15),
    .MAX_INSTR   (32'd20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      SIG_PHASE:  return {29'd0, bus.phase};
      SIG_STROBE: return {26'd0, bus.imem_en, bus.rf_read_en, bus.ex_en,
                          bus.mem_en, bus.rf_write_en, bus.pc_we};
      SIG_BUSY:   return {31'd0, bus.busy};
      SIG_HALTED: return {31'd0, bus.halted};
      SIG_MERR:   return {31'd0, bus.mem_error};
      default:    return bus.instr_count;
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle, plus a strobe exclusivity check.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.sig);
      total++;
      if (e.cyc != cyc || a !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", e.nm, cyc, a, e.val);
      end
    end
    total++;
    if ($countones({bus.imem_en, bus.rf_read_en, bus.ex_en, bus.mem_en, bus.rf_write_en}) > 1) begin
      bad++;
      $display("FAIL strobe_exclusive cyc=%0d actual=%b required=at_most_one", cyc,
               {bus.imem_en, bus.rf_read_en, bus.ex_en, bus.mem_en, bus.rf_write_en});
    end
  end

  task automatic push(input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // strobes = {imem_en, rf_read_en, ex_en, mem_en, rf_write_en, pc_we}
  task automatic chk(input string nm, input int ph, input logic [5:0] strobes,
                     input logic busy, input logic halted, input logic merr,
                     input logic [31:0] cnt);
    push(SIG_PHASE,  ph,             {nm, ".phase"});
    push(SIG_STROBE, {26'd0, strobes}, {nm, ".strobes"});
    push(SIG_BUSY,   {31'd0, busy},  {nm, ".busy"});
    push(SIG_HALTED, {31'd0, halted}, {nm, ".halted"});
    push(SIG_MERR,   {31'd0, merr},  {nm, ".mem_error"});
    push(SIG_COUNT,  cnt,            {nm, ".instr_count"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.halt_req  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    reset = 1'b1;

    // Single ALU instruction: 1,2,3,4,5,1 with write-back strobes in cycle 5.
    do_reset();
    chk("a_reset", 0, 6'b000000, 0, 0, 0, 0);
    bus.reg_write = 1'b1;
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("a_fetch", 1, 6'b100000, 1, 0, 0, 0);
    step(); chk("a_decode", 2, 6'b010000, 1, 0, 0, 0);
    step(); chk("a_execute", 3, 6'b001000, 1, 0, 0, 0);
    step(); chk("a_memory", 4, 6'b000000, 1, 0, 0, 0);
    step(); chk("a_wb", 5, 6'b000011, 1, 0, 0, 0);
    step(); chk("a_fetch2", 1, 6'b100000, 1, 0, 0, 1);

    // Load with three wait cycles: MEMORY lasts four cycles.
    do_reset();
    bus.mem_read  = 1'b1;
    bus.reg_write = 1'b1;
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    step(); step();
    step(); chk("b_mem1", 4, 6'b000100, 1, 0, 0, 0);
    step(); chk("b_mem2", 4, 6'b000100, 1, 0, 0, 0);
    step(); chk("b_mem3", 4, 6'b000100, 1, 0, 0, 0);
    step(); bus.mem_ready = 1'b1;
    chk("b_mem4", 4, 6'b000100, 1, 0, 0, 0);
    step(); bus.mem_ready = 1'b0; bus.mem_read = 1'b0;
    chk("b_wb", 5, 6'b000011, 1, 0, 0, 0);
    step(); chk("b_fetch2", 1, 6'b100000, 1, 0, 0, 1);

    // Store that never completes: halt with mem_error after 15 MEMORY cycles.
    do_reset();
    bus.mem_write = 1'b1;
    bus.reg_write = 1'b1;
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    step(); step();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("c_mem%0d", k), 4, 6'b000100, 1, 0, 0, 0);
    end
    step(); chk("c_halt", 6, 6'b000000, 0, 1, 1, 0);
    bus.run = 1'b1;
    step(); chk("c_hold", 6, 6'b000000, 0, 1, 1, 0);
    bus.run = 1'b0;
    bus.mem_write = 1'b0;

    // Instruction limit of 20: halted exactly 100 cycles after FETCH entry.
    do_reset();
    bus.reg_write = 1'b1;
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("d_fetch", 1, 6'b100000, 1, 0, 0, 0);
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 50)  chk("d_mid", 1, 6'b100000, 1, 0, 0, 10);
      if (n == 99)  chk("d_last_wb", 5, 6'b000011, 1, 0, 0, 19);
      if (n == 100) chk("d_halt", 6, 6'b000000, 0, 1, 0, 20);
    end

    // halt_req in DECODE is ignored; held through WRITEBACK it stops after counting.
    do_reset();
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("e_fetch", 1, 6'b100000, 1, 0, 0, 0);
    step(); bus.halt_req = 1'b1;
    chk("e_decode", 2, 6'b010000, 1, 0, 0, 0);
    step(); bus.halt_req = 1'b0;
    chk("e_execute", 3, 6'b001000, 1, 0, 0, 0);
    step(); chk("e_memory", 4, 6'b000000, 1, 0, 0, 0);
    step(); chk("e_wb", 5, 6'b000001, 1, 0, 0, 0);
    step(); chk("e_fetch2", 1, 6'b100000, 1, 0, 0, 1);
    bus.halt_req = 1'b1;
    step(); step(); step();
    step(); chk("e_wb2", 5, 6'b000001, 1, 0, 0, 1);
    step(); bus.halt_req = 1'b0;
    chk("e_halt", 6, 6'b000000, 0, 1, 0, 2);

    // Reset in the middle of a memory wait, then restart.
    do_reset();
    bus.reg_write = 1'b1;
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    repeat (5) step();
    chk("f_fetch2", 1, 6'b100000, 1, 0, 0, 1);
    bus.mem_read = 1'b1;
    step(); step();
    step(); chk("f_mem1", 4, 6'b000100, 1, 0, 0, 1);
    step(); chk("f_mem2", 4, 6'b000100, 1, 0, 0, 1);
    reset = 1'b1;
    step(); reset = 1'b0; bus.mem_read = 1'b0;
    chk("f_reset", 0, 6'b000000, 0, 0, 0, 0);
    bus.run = 1'b1;
    step(); bus.run = 1'b0;
    chk("f_restart", 1, 6'b100000, 1, 0, 0, 0);

    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
